step_arbiter: RTL and testbench

//   Shares one multi-cycle step-sequenced resource (e.g. multi-cycle ALU/CSR/memory

---
 rtl/step_arbiter.sv | 132 +++++++++++++
 tb/tb_step_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/step_arbiter.sv
// Round-robin arbiter that hands one step-sequenced resource to a requester,
// walks its job through step 0..len-1 and pulses done to the owner at the end.
module step_arbiter #(
    parameter int N = 2,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] len,
    output logic [N-1:0]   grant,
    output logic           busy,
    output logic [W-1:0]   step,
    output logic           step_vld,
    output logic [N-1:0]   done
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [N-1:0]    grant_reg, grant_next;
    logic [IW-1:0]   owner_reg, owner_next;
    logic [W-1:0]    len_reg, len_next;
    logic [W-1:0]    step_reg, step_next;
    logic [IW-1:0]   ptr_reg, ptr_next;

    logic [W-1:0]    len_arr  [N];
    logic [IW-1:0]   cand_idx [N];
    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   owner_succ;

    // cand_idx[k] is the k-th requester visited when scanning upward from the pointer
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            logic [IW:0] sum;
            assign len_arr[gi] = len[gi*W +: W];
            assign sum         = {1'b0, ptr_reg} + (IW+1)'(gi);
            assign cand_idx[gi] = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
        end
    endgenerate

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!win_found && req[cand_idx[k]]) begin
                win_found = 1'b1;
                win_idx   = cand_idx[k];
            end
        end
    end

    assign owner_succ = (owner_reg == IW'(N - 1)) ? '0 : owner_reg + IW'(1);

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        owner_next = owner_reg;
        len_next   = len_reg;
        step_next  = step_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            S_IDLE: begin
                if (win_found) begin
                    state_next          = S_RUN;
                    grant_next          = '0;
                    grant_next[win_idx] = 1'b1;
                    owner_next          = win_idx;
                    len_next            = (len_arr[win_idx] == '0) ? W'(1) : len_arr[win_idx];
                    step_next           = '0;
                end
            end
            S_RUN: begin
                // Owner withdrawing its request abandons the job without a done pulse
                if (!req[owner_reg]) begin
                    state_next = S_IDLE;
                    grant_next = '0;
                    step_next  = '0;
                    ptr_next   = owner_succ;
                end else if (step_reg == len_reg - W'(1)) begin
                    state_next = S_DONE;
                end else begin
                    step_next = step_reg + W'(1);
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
                grant_next = '0;
                step_next  = '0;
                ptr_next   = owner_succ;
            end
            default: begin
                state_next = S_IDLE;
                grant_next = '0;
                step_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            grant_reg <= '0;
            owner_reg <= '0;
            len_reg   <= '0;
            step_reg  <= '0;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            owner_reg <= owner_next;
            len_reg   <= len_next;
            step_reg  <= step_next;
            ptr_reg   <= ptr_next;
        end
    end

    assign grant    = grant_reg;
    assign busy     = (state_reg != S_IDLE);
    assign step     = step_reg;
    assign step_vld = (state_reg == S_RUN);
    assign done     = (state_reg == S_DONE) ? grant_reg : '0;

endmodule

// File: tb/tb_step_arbiter.sv
// Randomized and directed checks of step_arbiter against a job-level model.
module tb_step_arbiter;

    localparam int N = 2;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] len;
    logic [N-1:0]   grant;
    logic           busy;
    logic [W-1:0]   step;
    logic           step_vld;
    logic [N-1:0]   done;

    int errors = 0;
    int checks = 0;

    step_arbiter #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .req(req), .len(len),
        .grant(grant), .busy(busy), .step(step), .step_vld(step_vld), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Job-level model: who owns the resource, which step it is on, and whether
    // the current cycle is the completion cycle of that job.
    int m_owner = -1;
    int m_step  = 0;
    int m_len   = 0;
    int m_done  = -1;
    int m_ptr   = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1; m_step = 0; m_len = 0; m_done = -1; m_ptr = 0;
        end else if (m_done >= 0) begin
            m_ptr = (m_done + 1) % N; m_done = -1; m_owner = -1; m_step = 0;
        end else if (m_owner >= 0) begin
            if (!req[m_owner]) begin
                m_ptr = (m_owner + 1) % N; m_owner = -1; m_step = 0;
            end else if (m_step + 1 == m_len) begin
                m_done = m_owner;
            end else begin
                m_step = m_step + 1;
            end
        end else begin
            int  cand;
            bit  found;
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                cand = (m_ptr + k) % N;
                if (!found && req[cand]) begin
                    found   = 1'b1;
                    m_owner = cand;
                    m_len   = int'(len[cand*W +: W]);
                    if (m_len == 0) m_len = 1;
                    m_step  = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            logic [N-1:0] e_grant;
            logic [N-1:0] e_done;
            logic         e_vld;
            e_grant = '0;
            e_done  = '0;
            if (m_owner >= 0) e_grant[m_owner] = 1'b1;
            if (m_done >= 0)  e_done[m_done]   = 1'b1;
            e_vld = (m_owner >= 0) && (m_done < 0);
            chk("grant", grant, e_grant);
            chk("busy", busy, m_owner >= 0);
            chk("step_vld", step_vld, e_vld);
            chk("done", done, e_done);
            if (e_vld) chk("step", step, m_step);
            chk("grant_onehot0", $onehot0(grant), 1);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_len(input int i, input int v);
        len[i*W +: W] = W'(v);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int cnt;
        int last;
        rst = 1'b1;
        req = '0;
        len = '0;
        tick();
        tick();
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_step", step, 0);
        chk("rst_vld", step_vld, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;

        // single job of length 3
        req = 2'b01; set_len(0, 3);
        tick(); chk("t1_grant", grant, 2'b01); chk("t1_s0", step, 0); chk("t1_vld0", step_vld, 1);
        tick(); chk("t1_s1", step, 1);
        tick(); chk("t1_s2", step, 2);
        tick(); chk("t1_done", done, 2'b01); chk("t1_vld_done", step_vld, 0); chk("t1_grant_held", grant, 2'b01);
        req = 2'b00;
        tick(); chk("t1_idle_grant", grant, 0); chk("t1_idle_busy", busy, 0);

        // zero length runs as one step
        req = 2'b01; set_len(0, 0);
        tick(); chk("t3_grant", grant, 2'b01); chk("t3_s0", step, 0);
        tick(); chk("t3_done", done, 2'b01);
        req = 2'b00;
        tick();

        // both requesting continuously alternate fairly
        pulse_reset();
        req = 2'b11; set_len(0, 2); set_len(1, 2);
        for (int j = 0; j < 4; j++) begin
            tick(); chk("t2_grant", grant, (j % 2 == 0) ? 2'b01 : 2'b10); chk("t2_s0", step, 0);
            tick(); chk("t2_s1", step, 1);
            tick(); chk("t2_done", done, (j % 2 == 0) ? 2'b01 : 2'b10);
            tick(); chk("t2_gap", grant, 0);
        end
        req = 2'b00;
        tick();

        // abort at step 1, then requester 1 takes over
        pulse_reset();
        req = 2'b01; set_len(0, 5);
        tick(); chk("t4_grant", grant, 2'b01);
        tick(); chk("t4_s1", step, 1);
        req = 2'b10; set_len(1, 2);
        tick(); chk("t4_abort_grant", grant, 0); chk("t4_abort_done", done, 0);
        tick(); chk("t4_next_grant", grant, 2'b10);
        tick();
        tick(); chk("t4_done1", done, 2'b10);
        req = 2'b00;
        tick();

        // async reset mid-run clears outputs immediately and the pointer
        req = 2'b01; set_len(0, 1);
        tick(); tick(); chk("t5_pre_done", done, 2'b01);
        req = 2'b00;
        tick();
        req = 2'b01; set_len(0, 10);
        tick(); tick(); chk("t5_running", step_vld, 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_grant", grant, 0); chk("t5_busy", busy, 0); chk("t5_step", step, 0);
        chk("t5_vld", step_vld, 0); chk("t5_done", done, 0);
        tick();
        rst = 1'b0;
        req = 2'b11; set_len(0, 2); set_len(1, 2);
        tick(); chk("t5_ptr0_grant", grant, 2'b01);
        tick();
        tick(); chk("t5_done_after", done, 2'b01);
        req = 2'b00;
        tick();

        // maximum length job
        req = 2'b01; set_len(0, 255);
        cnt = 0; last = -1;
        for (int c = 0; c < 300 && done == 0; c++) begin
            tick();
            if (step_vld) begin cnt++; last = int'(step); end
        end
        chk("t6_count", cnt, 255);
        chk("t6_last", last, 254);
        chk("t6_done", done, 2'b01);
        req = 2'b00;
        tick();

        // random traffic; requesters hold until done, occasionally abort
        for (int c = 0; c < 4000; c++) begin
            logic [N-1:0] d;
            d = done;
            for (int i = 0; i < N; i++) begin
                if (d[i]) begin
                    req[i] = ($urandom_range(0, 3) == 0);
                    set_len(i, ($urandom_range(0, 7) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 6));
                end else if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[i] = 1'b1;
                        set_len(i, ($urandom_range(0, 7) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 6));
                    end
                end else if (grant[i] && step_vld) begin
                    if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
                    else if ($urandom_range(0, 4) == 0) set_len(i, $urandom_range(0, 255));
                end
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
